// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, NOP,
// EX redirect-select encodings and the IF/ID register layout.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_BUF   = 2'b10,
        ST_DRAIN = 2'b11
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] PCSRC_NONE   = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;
    localparam logic [1:0] PCSRC_RSVD   = 2'b11;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_dffREC.sv
// Generic register with asynchronous active-low reset, enable and a
// synchronous clear that loads a caller-supplied clear value.
module dffREC #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] clr_d_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Clear wins over enable so a flush is never lost to a stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RST_VAL;
        end else if (clr_i) begin
            q_q <= clr_d_i;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory request, one-entry
// response buffer for stalls, EX/ID redirects and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        Fi_stall,
    input  logic        Di_flush,
    input  logic [1:0]  Ei_prePCSrc,
    input  logic [31:0] Ei_branchTarget,
    input  logic [31:0] Ei_jalrTarget,
    input  logic        Di_jal,
    input  logic [31:0] Di_jalTarget,
    output logic        Fo_imemReq,
    output logic [31:0] Fo_imemAddr,
    input  logic        Fi_imemReady,
    input  logic [31:0] Fi_imemRdata,
    output logic [31:0] Do_inst,
    output logic [31:0] Do_PC,
    output logic [31:0] Do_PCPlus4,
    output logic        Do_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  buf_q;

    logic         redirect;
    logic [31:0]  redirect_tgt;
    logic         deliver;
    logic [31:0]  deliver_inst;
    logic         buf_load;

    ifid_t        ifid_d, ifid_bubble, ifid_q;

    always_comb begin
        redirect     = 1'b0;
        redirect_tgt = pc_q;
        if (Ei_prePCSrc == PCSRC_BRANCH) begin
            redirect     = 1'b1;
            redirect_tgt = Ei_branchTarget;
        end else if (Ei_prePCSrc == PCSRC_JALR) begin
            redirect     = 1'b1;
            redirect_tgt = Ei_jalrTarget;
        end else if (Di_jal && ifid_q.valid) begin
            redirect     = 1'b1;
            redirect_tgt = Di_jalTarget;
        end
    end

    always_comb begin
        state_d      = state_q;
        deliver      = 1'b0;
        deliver_inst = Fi_imemRdata;
        buf_load     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                // A redirect with the response still in flight must wait it out.
                if (redirect) begin
                    state_d = Fi_imemReady ? ST_FETCH : ST_DRAIN;
                end else if (Fi_imemReady) begin
                    if (Fi_stall) begin
                        state_d  = ST_BUF;
                        buf_load = 1'b1;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            ST_BUF: begin
                if (redirect) begin
                    state_d = ST_FETCH;
                end else if (!Fi_stall) begin
                    state_d      = ST_FETCH;
                    deliver      = 1'b1;
                    deliver_inst = buf_q;
                end
            end
            ST_DRAIN: begin
                if (Fi_imemReady) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pc_d = redirect ? redirect_tgt : (deliver ? pc_inc(pc_q) : pc_q);

        // The request address may only move when no request is left unanswered.
        req_addr_d = req_addr_q;
        if ((state_d == ST_FETCH) && !((state_q == ST_FETCH) && !Fi_imemReady)) begin
            req_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_load) begin
            buf_q <= Fi_imemRdata;
        end
    end

    always_comb begin
        ifid_bubble = '{inst: NOP_INST, pc: ifid_q.pc, pc_plus4: ifid_q.pc_plus4, valid: 1'b0};
        ifid_d      = ifid_bubble;
        if (deliver) begin
            ifid_d = '{inst: deliver_inst, pc: pc_q, pc_plus4: pc_inc(pc_q), valid: 1'b1};
        end
    end

    dffREC #(
        .WIDTH   ($bits(ifid_t)),
        .RST_VAL ({NOP_INST, 32'h0, 32'h0, 1'b0})
    ) u_ifid (
        .clk_i   (clk),
        .rst_ni  (reset_x),
        .en_i    (!Fi_stall),
        .clr_i   (Di_flush | redirect),
        .clr_d_i (ifid_bubble),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign Fo_imemReq  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign Fo_imemAddr = req_addr_q;
    assign Do_inst     = ifid_q.inst;
    assign Do_PC       = ifid_q.pc;
    assign Do_PCPlus4  = ifid_q.pc_plus4;
    assign Do_valid    = ifid_q.valid;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded at reset.
REQ-002 SHALL have port clk  in  1  the single clock.
REQ-003 SHALL have port reset_x  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port Fi_stall  in  1  hazard stall: hold PC and IF/ID.
REQ-005 SHALL have port Di_flush  in  1  hazard flush of IF/ID.
REQ-006 SHALL have port Ei_prePCSrc  in  2  EX redirect select: 00 none, 01 Ei_branchTarget, 10 Ei_jalrTarget, 11 reserved (treated as 00).
REQ-007 SHALL have ports Ei_branchTarget, Ei_jalrTarget  in  32  EX redirect targets.
REQ-008 SHALL have ports Di_jal  in  1 and Di_jalTarget  in  32  ID-stage jal redirect.
REQ-009 SHALL have ports Fo_imemReq  out  1 and Fo_imemAddr  out  32  instruction-memory request.
REQ-010 SHALL have ports Fi_imemReady  in  1 and Fi_imemRdata  in  32  memory response, data valid when ready=1.
REQ-011 SHALL have ports Do_inst, Do_PC, Do_PCPlus4  out  32 and Do_valid  out  1  IF/ID register contents.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, BUF, DRAIN.
REQ-013 IDLE SHALL last one cycle after reset release, then go to FETCH with reqAddr=PC.
REQ-014 In FETCH, Fo_imemReq SHALL be 1 and Fo_imemAddr SHALL be reqAddr, held stable until Fi_imemReady=1.
REQ-015 FETCH with ready=1, no stall, no redirect: IF/ID SHALL load {Rdata, reqAddr, reqAddr+4, valid=1} next edge; PC and reqAddr SHALL become reqAddr+4; state stays FETCH (one instruction per cycle at zero-wait memory).
REQ-016 FETCH with ready=1 and Fi_stall=1: response SHALL be captured in a one-entry buffer, go to BUF, Fo_imemReq=0.
REQ-017 BUF with Fi_stall=0: IF/ID SHALL load buffer contents, PC advances by 4, return to FETCH.
REQ-018 Redirect priority SHALL be Ei_prePCSrc (01/10) > Di_jal (only when Do_valid=1) > sequential.
REQ-019 Redirect SHALL override Fi_stall, load PC with the target, discard buffer, and load IF/ID bubble next edge.
REQ-020 Redirect in FETCH with ready=0 SHALL go to DRAIN; DRAIN keeps req=1 with old reqAddr, discards the response on ready=1, then FETCH with reqAddr=PC.
REQ-021 Redirect in FETCH with ready=1 SHALL drop that response and stay FETCH with reqAddr=target.
REQ-022 A later redirect during DRAIN SHALL overwrite the pending PC target.
REQ-023 Bubble SHALL be Do_inst=NOP 32'h0000_0013, Do_valid=0, Do_PC/Do_PCPlus4 unchanged.
REQ-024 Di_flush SHALL load a bubble regardless of Fi_stall; fetch state unaffected.
REQ-025 Fi_stall=1 without redirect SHALL hold IF/ID and PC unchanged.
REQ-026 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 At most one memory request SHALL be outstanding.

Reset
REQ-028 On reset_x=0, asynchronously: state=IDLE, PC=reqAddr=RESET_PC, Fo_imemReq=0, Do_inst=NOP, Do_PC=Do_PCPlus4=0, Do_valid=0, buffer empty.
REQ-029 Reset mid-request SHALL abandon the request; no response is consumed until FETCH re-entered.

Structure
REQ-030 Shared package SHALL hold FSM state encoding, NOP constant, prePCSrc encodings.
REQ-031 IF/ID register SHALL be an instance of existing dffREC (enable=!stall, clear=flush|redirect).

Verification
REQ-032 Reset release, ready=1 always: addresses 0,4,8 on consecutive cycles; Do_inst matches data one cycle later, Do_valid=1.
REQ-033 Ready after 3 wait cycles: Fo_imemAddr constant 3 cycles; one IF/ID load only.
REQ-034 Stall 2 cycles coincident with ready at addr 8: BUF entered, req=0; after stall, Do_PC=8, next addr 12.
REQ-035 prePCSrc=01, target 0x100 while FETCH pending at 0x10: DRAIN, response discarded, next Fo_imemAddr=0x100, Do_valid=0 meanwhile.
REQ-036 prePCSrc=10 and Di_jal same cycle: PC=Ei_jalrTarget; Di_flush with stall: bubble loaded.
REQ-037 RESET_PC=32'hFFFF_FFFC: second fetch address 0; reset_x low during DRAIN returns to IDLE, req=0.
